// File: rtl/qns_pkg.sv
// qns_pkg: shared definitions for the quantised noise-shaping sequencer.
//   qns_state_e   - sequencer state encoding
//   QNS_SAT_LEVEL - magnitude of the modulator's saturated output level
package qns_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_RUN     = 2'd2,
    ST_RECOVER = 2'd3
  } qns_state_e;

  localparam int QNS_SAT_LEVEL = 3;

endpackage

// File: rtl/qns_ovl_detect.sv
// qns_ovl_detect: counts consecutive saturated modulator outputs.
//   clock - rising-edge clock
//   level - modulator output level (signed, LEVEL_W bits)
//   valid - level is meaningful this cycle (already gated to RUN by caller)
//   clear - synchronous clear of the run-length count
//   hit   - this cycle is the LIMIT-th consecutive saturation
// Invalid cycles leave the count untouched; a valid non-saturated level
// restarts it. The count clears itself on a hit.
module qns_ovl_detect import qns_pkg::*; #(
  parameter int LEVEL_W = 3,
  parameter int LIMIT   = 16
) (
  input  logic               clock,
  input  logic [LEVEL_W-1:0] level,
  input  logic               valid,
  input  logic               clear,
  output logic               hit
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [LEVEL_W-1:0] POS = LEVEL_W'(QNS_SAT_LEVEL);
  localparam logic [LEVEL_W-1:0] NEG = LEVEL_W'(-QNS_SAT_LEVEL);

  logic [CNT_W-1:0] cnt;
  logic             sat;

  assign sat = (level == POS) || (level == NEG);
  assign hit = valid && sat && (cnt == CNT_W'(LIMIT - 1));

  always_ff @(posedge clock) begin
    if (clear) begin
      cnt <= '0;
    end else if (valid) begin
      if (!sat || hit) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/qns_sequencer.sv
// qns_sequencer: feeds held input samples to a noise-shaping modulator,
// repeating each sample cfg_osr times, and resets the modulator after an
// overload (a long run of saturated outputs).
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   enable                - run request
//   cfg_osr               - modulator steps per sample (0 behaves as 1)
//   s_valid/s_data/s_ready- input sample handshake
//   mod_valid/mod_in      - modulator drive; mod_in is the registered held sample
//   mod_reset             - modulator reset (IDLE and RECOVER)
//   mod_out/mod_valid_out - modulator output observed for saturation
//   overload/underrun     - registered one-cycle pulses, asserted the cycle
//                           after the triggering RUN cycle
module qns_sequencer import qns_pkg::*; #(
  parameter int IN_W      = 19,
  parameter int OUT_W     = 3,
  parameter int OSR_W     = 8,
  parameter int OVL_LIMIT = 16,
  parameter int RCV_CYC   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [OSR_W-1:0] cfg_osr,
  input  logic             s_valid,
  input  logic [IN_W-1:0]  s_data,
  output logic             s_ready,
  output logic             mod_valid,
  output logic [IN_W-1:0]  mod_in,
  output logic             mod_reset,
  input  logic [OUT_W-1:0] mod_out,
  input  logic             mod_valid_out,
  output logic             overload,
  output logic             underrun
);

  localparam int RCV_W = (RCV_CYC > 1) ? $clog2(RCV_CYC) : 1;

  qns_state_e       state;
  logic [OSR_W-1:0] phase;
  logic [OSR_W-1:0] osr_q;
  logic [OSR_W-1:0] osr_next;
  logic [IN_W-1:0]  hold;
  logic [RCV_W-1:0] rcv_cnt;
  logic             in_run, boundary, hit, take;
  logic             overload_q, underrun_q;

  assign in_run   = (state == ST_RUN);
  assign boundary = in_run && (phase == osr_q - 1'b1);
  assign osr_next = (cfg_osr == '0) ? OSR_W'(1) : cfg_osr;

  // Overload wins over a coincident boundary, so the pending sample stays
  // pending and is replayed-then-replaced only after RECOVER.
  assign s_ready   = (state == ST_FILL) || (boundary && !hit && enable);
  assign take      = s_valid && s_ready;
  assign mod_valid = in_run;
  assign mod_reset = (state == ST_IDLE) || (state == ST_RECOVER);
  assign mod_in    = hold;
  assign overload  = overload_q;
  assign underrun  = underrun_q;

  qns_ovl_detect #(
    .LEVEL_W (OUT_W),
    .LIMIT   (OVL_LIMIT)
  ) u_ovl (
    .clock (clock),
    .level (mod_out),
    .valid (mod_valid_out && in_run),
    .clear (reset),
    .hit   (hit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase      <= '0;
      osr_q      <= OSR_W'(1);
      hold       <= '0;
      rcv_cnt    <= '0;
      overload_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      overload_q <= hit;
      underrun_q <= 1'b0;
      if (take) begin
        hold  <= s_data;
        osr_q <= osr_next;
        phase <= '0;
      end
      case (state)
        ST_IDLE: if (enable) state <= ST_FILL;
        ST_FILL: begin
          if (take)         state <= ST_RUN;
          else if (!enable) state <= ST_IDLE;
        end
        ST_RUN: begin
          if (hit) begin
            state   <= ST_RECOVER;
            phase   <= '0;
            rcv_cnt <= '0;
          end else if (boundary) begin
            // take already reloaded hold/phase; otherwise the run ends here
            if (!take) begin
              if (!enable) begin
                state <= ST_IDLE;
              end else begin
                state      <= ST_FILL;
                underrun_q <= 1'b1;
              end
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_RECOVER: begin
          if (rcv_cnt == RCV_W'(RCV_CYC - 1)) begin
            state <= ST_RUN;
            phase <= '0;
          end else begin
            rcv_cnt <= rcv_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qns_sequencer.sv
module tb_qns_sequencer;

  localparam int IN_W = 19, OUT_W = 3, OSR_W = 8, OVL = 16, RCV = 2;
  localparam int M_IDLE = 0, M_FILL = 1, M_RUN = 2, M_RCV = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [OSR_W-1:0]  cfg_osr = 8'd4;
  logic              s_valid = 1'b0;
  logic [IN_W-1:0]   s_data = '0;
  logic              s_ready, mod_valid, mod_reset, overload, underrun;
  logic [IN_W-1:0]   mod_in;
  logic [OUT_W-1:0]  mod_out = '0;
  logic              mod_valid_out = 1'b0;

  qns_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .OSR_W(OSR_W), .OVL_LIMIT(OVL), .RCV_CYC(RCV)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .cfg_osr(cfg_osr),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mod_valid(mod_valid), .mod_in(mod_in), .mod_reset(mod_reset),
    .mod_out(mod_out), .mod_valid_out(mod_valid_out),
    .overload(overload), .underrun(underrun)
  );

  always #5 clock = ~clock;

  int errors = 0, checks = 0, cyc = 0;
  int cap_val[$];
  int cap_cyc[$];
  int n_ov, n_un, n_mrst, n_rdy;

  // model: sequence position expressed as repeats remaining for the sample
  int              m_st, m_osr, m_left, m_rcv, m_sat;
  logic [IN_W-1:0] m_hold;
  bit              m_ov, m_un, sat_now, hit, bnd, e_rdy;

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, a, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic clr();
    cap_val.delete(); cap_cyc.delete();
    n_ov = 0; n_un = 0; n_mrst = 0; n_rdy = 0;
  endtask

  task automatic send(input int d);
    bit hs;
    int n;
    s_valid = 1'b1; s_data = IN_W'(d); hs = 1'b0; n = 0;
    while (!hs && n < 200) begin
      @(negedge clock); hs = s_ready;
      @(posedge clock); #1; n++;
    end
    s_valid = 1'b0;
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL send_handshake data=%0d: got none expected handshake", d);
    end
  endtask

  task automatic model_step();
    int lvl;
    lvl     = int'($signed(mod_out));
    sat_now = (m_st == M_RUN) && mod_valid_out && (lvl == 3 || lvl == -3);
    hit     = sat_now && (m_sat + 1 >= OVL);
    bnd     = (m_st == M_RUN) && (m_left == 1);
    e_rdy   = (m_st == M_FILL) || (bnd && !hit && enable);

    cmp("s_ready",   32'(s_ready),   32'(e_rdy));
    cmp("mod_valid", 32'(mod_valid), 32'(m_st == M_RUN));
    cmp("mod_reset", 32'(mod_reset), 32'(m_st == M_IDLE || m_st == M_RCV));
    cmp("mod_in",    32'(mod_in),    32'(m_hold));
    cmp("overload",  32'(overload),  32'(m_ov));
    cmp("underrun",  32'(underrun),  32'(m_un));
    cmp("pulse_excl", 32'(overload && underrun), 32'(0));

    if (mod_valid) begin cap_val.push_back(int'($signed(mod_in))); cap_cyc.push_back(cyc); end
    if (overload)  n_ov++;
    if (underrun)  n_un++;
    if (mod_reset) n_mrst++;
    if (s_ready)   n_rdy++;

    m_ov = hit; m_un = 1'b0;
    if (m_st == M_RUN && mod_valid_out) m_sat = hit ? 0 : (sat_now ? m_sat + 1 : 0);
    case (m_st)
      M_IDLE: if (enable) m_st = M_FILL;
      M_FILL: begin
        if (s_valid) begin
          m_hold = s_data; m_osr = (cfg_osr == 0) ? 1 : int'(cfg_osr);
          m_left = m_osr; m_st = M_RUN;
        end else if (!enable) m_st = M_IDLE;
      end
      M_RUN: begin
        if (hit) begin m_st = M_RCV; m_rcv = RCV; end
        else if (bnd) begin
          if (!enable) m_st = M_IDLE;
          else if (s_valid) begin
            m_hold = s_data; m_osr = (cfg_osr == 0) ? 1 : int'(cfg_osr); m_left = m_osr;
          end else begin m_un = 1'b1; m_st = M_FILL; end
        end else m_left--;
      end
      default: begin
        m_rcv--;
        if (m_rcv == 0) begin m_st = M_RUN; m_left = m_osr; end
      end
    endcase
  endtask

  initial begin
    m_st = M_IDLE; m_hold = '0; m_osr = 1; m_left = 0; m_rcv = 0; m_sat = 0;
    m_ov = 0; m_un = 0;
    clr();
    fork
      forever begin
        @(negedge clock);
        cyc++;
        if (reset) begin
          m_st = M_IDLE; m_hold = '0; m_osr = 1; m_left = 0; m_rcv = 0; m_sat = 0;
          m_ov = 0; m_un = 0;
        end else model_step();
      end
      begin
        // reset state
        tick(3); reset = 1'b0;
        @(negedge clock);
        cmp("rst_mod_reset", 32'(mod_reset), 32'(1));
        cmp("rst_s_ready",   32'(s_ready),   32'(0));
        cmp("rst_mod_in",    32'(mod_in),    32'(0));
        @(posedge clock); #1;

        // osr 4, two back-to-back samples
        enable = 1'b1; cfg_osr = 8'd4; clr();
        send(100); send(200); tick(8);
        cmp("b2b_count", 32'(cap_val.size()), 32'(8));
        for (int i = 0; i < 8; i++) cmp("b2b_val", 32'(cap_val[i]), (i < 4) ? 32'(100) : 32'(200));
        cmp("b2b_span", 32'(cap_cyc[7] - cap_cyc[0]), 32'(7));
        cmp("b2b_underrun", 32'(n_un), 32'(1));

        // osr 0 behaves as 1
        cfg_osr = 8'd0; clr();
        send(5); tick(4);
        cmp("osr0_count", 32'(cap_val.size()), 32'(1));
        cmp("osr0_val",   32'(cap_val[0]), 32'(5));
        cmp("osr0_underrun", 32'(n_un), 32'(1));

        // 16 saturated outputs -> overload, 2-cycle recover, replay
        cfg_osr = 8'd40; clr();
        send(7);
        mod_out = 3'sd3; mod_valid_out = 1'b1; tick(16); mod_valid_out = 1'b0;
        tick(50);
        cmp("ovl_pulses", 32'(n_ov), 32'(1));
        cmp("ovl_mod_reset_cycles", 32'(n_mrst), 32'(2));
        cmp("ovl_count", 32'(cap_val.size()), 32'(56));
        cmp("ovl_last_val", 32'(cap_val[55]), 32'(7));

        // broken run of saturation -> no overload
        clr();
        send(9);
        mod_valid_out = 1'b1;
        mod_out = -3'sd3; tick(15); mod_out = 3'sd1; tick(1);
        mod_out = 3'sd3;  tick(15); mod_out = 3'sd0; tick(1);
        mod_valid_out = 1'b0; tick(15);
        cmp("nosat_ovl", 32'(n_ov), 32'(0));
        cmp("nosat_count", 32'(cap_val.size()), 32'(40));

        // overload coincident with boundary while a sample is pending
        cfg_osr = 8'd16; clr();
        send(11);
        s_valid = 1'b1; s_data = IN_W'(22);
        mod_out = 3'sd3; mod_valid_out = 1'b1; tick(16); mod_valid_out = 1'b0;
        send(22); tick(20);
        cmp("coinc_ovl", 32'(n_ov), 32'(1));
        cmp("coinc_count", 32'(cap_val.size()), 32'(48));
        begin
          int k;
          k = 0;
          for (int i = 0; i < 32; i++) if (cap_val[i] == 11) k++;
          cmp("coinc_replay", 32'(k), 32'(32));
        end
        cmp("coinc_new", 32'(cap_val[32]), 32'(22));

        // reset mid-RUN at phase 2 of 4
        cfg_osr = 8'd4;
        send(33); tick(2);
        reset = 1'b1; tick(1); reset = 1'b0;
        @(negedge clock);
        cmp("mrst_mod_valid", 32'(mod_valid), 32'(0));
        cmp("mrst_mod_in",    32'(mod_in),    32'(0));
        cmp("mrst_mod_reset", 32'(mod_reset), 32'(1));
        cmp("mrst_s_ready",   32'(s_ready),   32'(0));
        cmp("mrst_pulses",    32'(overload | underrun), 32'(0));
        @(posedge clock); #1;
        clr();
        send(44); tick(6);
        cmp("mrst_restart_count", 32'(cap_val.size()), 32'(4));
        cmp("mrst_restart_val",   32'(cap_val[0]), 32'(44));

        // enable drop ends the run at the boundary without taking a sample
        clr();
        send(55);
        enable = 1'b0; s_valid = 1'b1; s_data = IN_W'(66); n_rdy = 0;
        tick(8); s_valid = 1'b0;
        cmp("dis_count", 32'(cap_val.size()), 32'(4));
        cmp("dis_underrun", 32'(n_un), 32'(0));
        cmp("dis_ready", 32'(n_rdy), 32'(0));
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qns_sequencer.md
QNS_SEQUENCER -- requirements
Module: qns_sequencer

Interface
REQ-001 SHALL have parameter IN_W, default 19, meaning sample width, s(19,15) signed.
REQ-002 SHALL have parameter OUT_W, default 3, meaning modulator output level width, signed.
REQ-003 SHALL have parameter OSR_W, default 8, meaning cfg_osr width.
REQ-004 SHALL have parameter OVL_LIMIT, default 16, meaning consecutive saturated outputs that declare overload.
REQ-005 SHALL have parameter RCV_CYC, default 2, meaning modulator reset pulse length in cycles.
REQ-006 clock  input  1  sole clock, rising edge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 enable  input  1  run request.
REQ-009 cfg_osr  input  OSR_W  modulator steps per input sample; 0 treated as 1.
REQ-010 s_valid  input  1  input sample valid.
REQ-011 s_data  input  IN_W  input sample, signed.
REQ-012 s_ready  output  1  sample accepted when s_valid && s_ready.
REQ-013 mod_valid  output  1  drives modulator valid_in.
REQ-014 mod_in  output  IN_W  drives modulator in; held sample.
REQ-015 mod_reset  output  1  drives modulator reset.
REQ-016 mod_out  input  OUT_W  modulator output level.
REQ-017 mod_valid_out  input  1  modulator output valid.
REQ-018 overload  output  1  one-cycle pulse on overload detection.
REQ-019 underrun  output  1  one-cycle pulse when no sample is available at a sample boundary.

Function
REQ-020 SHALL implement states IDLE, FILL, RUN, RECOVER.
REQ-021 IDLE: mod_valid=0, s_ready=0, mod_reset=1; enable=1 -> FILL.
REQ-022 FILL: s_ready=1, mod_valid=0, mod_reset=0; on handshake latch s_data into hold register, latch max(cfg_osr,1) into osr_q, phase=0, -> RUN; enable=0 -> IDLE.
REQ-023 RUN: mod_valid=1 every cycle, mod_in=hold register, phase increments by 1 per cycle.
REQ-024 RUN boundary (phase==osr_q-1, no overload hit): s_ready=1; handshake loads a new sample and cfg_osr, sets phase=0, stays RUN with no mod_valid gap.
REQ-025 RUN boundary without s_valid: underrun pulses, -> FILL; with enable=0: -> IDLE, no sample taken, no underrun.
REQ-026 First mod_valid SHALL occur the cycle after the FILL handshake; mod_in SHALL be registered and stable for exactly osr_q mod_valid cycles per sample.
REQ-027 Saturation: mod_valid_out=1 and mod_out equal to +3 or -3; counted only in RUN; a non-saturated valid output clears the count; cycles with mod_valid_out=0 leave it unchanged.
REQ-028 Overload hit: the OVL_LIMIT-th consecutive saturation; overload pulses, count clears, -> RECOVER.
REQ-029 Overload hit takes priority over a coincident boundary: s_ready=0 that cycle and no sample is consumed.
REQ-030 RECOVER: mod_reset=1, mod_valid=0, s_ready=0 for exactly RCV_CYC cycles, then -> RUN with phase=0 replaying the held sample.
REQ-031 enable=0 during RECOVER SHALL take effect at the next RUN boundary.
REQ-032 Phase counter width OSR_W; osr_q=1 SHALL make every RUN cycle a boundary.
REQ-033 overload and underrun SHALL never assert in the same cycle.

Reset
REQ-034 While reset=1: state=IDLE, phase=0, saturation count=0, hold=0, osr_q=1, and on the cycle after reset, s_ready=0, mod_valid=0, mod_in=0, mod_reset=1, overload=0, underrun=0.
REQ-035 Reset mid-RUN or mid-RECOVER SHALL abandon the held sample with no pulse outputs.

Structure
REQ-036 Shared package qns_pkg SHALL hold the state enum and constant QNS_SAT_LEVEL=3.
REQ-037 Saturation counting SHALL be sub-module qns_ovl_detect: inputs level, valid, clear; output hit.

Verification
REQ-038 enable=1, cfg_osr=4, samples 100,200 back-to-back -> mod_valid continuous; mod_in=100 for 4 cycles then 200 for 4; no underrun.
REQ-039 cfg_osr=0, one sample of 5 -> exactly one mod_valid cycle with mod_in=5, then underrun pulse, state FILL.
REQ-040 mod_out forced to 3 with mod_valid_out=1 for 16 cycles -> overload on the 16th; mod_reset=1 for 2 cycles; RUN resumes with the same sample, phase 0.
REQ-041 15 saturated outputs, one 1, then 15 saturated -> no overload.
REQ-042 Overload hit coincident with boundary and s_valid=1 -> s_ready=0, sample stays pending, accepted at the first boundary after RECOVER.
REQ-043 reset asserted mid-RUN (phase 2 of 4) -> next cycle IDLE values per REQ-034; re-enable restarts from FILL.
